// File: rtl/cpu_run_ctrl_pkg.sv
// Shared run-control encodings, used by the run controller and the
// debug display driver.
package cpu_run_ctrl_pkg;

    localparam int unsigned RS_W     = 2;
    localparam int unsigned CE_CNT_W = 32;

    typedef enum logic [RS_W-1:0] {
        ST_STEP = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } run_state_e;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-side bundle of the run controller: raw controls, breakpoint,
// PC in; clock enable and debug status out.
interface cpu_run_ctrl_if #(
    parameter int unsigned PC_W = 32
);
    import cpu_run_ctrl_pkg::*;

    logic                cont;
    logic                step;
    logic                bp_en;
    logic [PC_W-1:0]     bp_addr;
    logic [PC_W-1:0]     pc;
    logic                cpu_ce;
    logic                halted;
    logic [RS_W-1:0]     run_state;
    logic [CE_CNT_W-1:0] ce_count;

    modport master (
        output cont, step, bp_en, bp_addr, pc,
        input  cpu_ce, halted, run_state, ce_count
    );

    modport slave (
        input  cont, step, bp_en, bp_addr, pc,
        output cpu_ce, halted, run_state, ce_count
    );

endinterface

// File: rtl/cpu_run_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability-count debouncer
// and a registered one-cycle pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CNT_W =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            // any cycle of agreement restarts the stability count
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync2_q;
                    rise_q  <= sync2_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// CPU run control: step / continuous run / breakpoint halt, issuing
// single-cycle clock enables and counting them for the debug display.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned RUN_DIV         = 100000000,
    parameter int unsigned PC_W            = 32
) (
    input  logic         clk100m,
    input  logic         rst,
    cpu_run_ctrl_if.slave bus
);

    localparam int unsigned DIV_W =
        (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

    logic                cont_s1_q;
    logic                cont_s2_q;
    logic                step_edge;
    logic                bp_hit;
    logic                div_tc;
    run_state_e          state_q;
    logic [DIV_W-1:0]    div_q;
    logic                ce_q;
    logic [CE_CNT_W-1:0] cnt_q;
    logic [PC_W-1:0]     pc_w;
    logic [PC_W-1:0]     bp_w;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .clk_i (clk100m),
        .rst_i (rst),
        .btn_i (bus.step),
        .rise_o(step_edge)
    );

    // cont is a level switch: synchronized only, never debounced
    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            cont_s1_q <= 1'b0;
            cont_s2_q <= 1'b0;
        end else begin
            cont_s1_q <= bus.cont;
            cont_s2_q <= cont_s1_q;
        end
    end

    assign pc_w   = PC_W'(bus.pc);
    assign bp_w   = PC_W'(bus.bp_addr);
    assign bp_hit = bus.bp_en && (pc_w == bp_w);
    assign div_tc = (div_q == DIV_LAST);

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state_q <= ST_STEP;
            div_q   <= '0;
            ce_q    <= 1'b0;
        end else begin
            ce_q <= 1'b0;
            unique case (state_q)
                ST_STEP: begin
                    ce_q <= step_edge;
                    if (cont_s2_q) begin
                        state_q <= ST_RUN;
                        div_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (!cont_s2_q) begin
                        state_q <= ST_STEP;
                        div_q   <= '0;
                    end else if (div_tc) begin
                        div_q <= '0;
                        if (bp_hit) begin
                            state_q <= ST_HALT;
                        end else begin
                            ce_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_HALT: begin
                    // a step here walks over the breakpoint
                    ce_q <= step_edge;
                    if (!cont_s2_q) begin
                        state_q <= ST_STEP;
                    end
                end
                default: begin
                    state_q <= ST_STEP;
                    div_q   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (ce_q) begin
            cnt_q <= cnt_q + CE_CNT_W'(1);
        end
    end

    assign bus.cpu_ce    = ce_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.run_state = state_q;
    assign bus.ce_count  = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Testbench for cpu_run_ctrl: directed scenarios plus random stimulus
// against a schedule-based reference model.
module tb_cpu_run_ctrl;
    import cpu_run_ctrl_pkg::*;

    localparam int DB = 4;
    localparam int RD = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.PC_W(32)) bus ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (RD),
        .PC_W           (32)
    ) dut (
        .clk100m(clk),
        .rst    (rst),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    int          n;
    bit          q_step[$];
    bit          q_cont[$];
    bit          m_db;
    int          m_dis;
    bit          m_edge;
    int          m_state;
    int          m_due;
    bit          m_ce;
    logic [31:0] m_cnt;

    // observation / CPU stand-in
    bit cpu_auto;
    bit prev_ce;
    int pulses;
    int last_pulse_n;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q_step  = '{1'b0, 1'b0};
        q_cont  = '{1'b0, 1'b0};
        m_db    = 1'b0;
        m_dis   = 0;
        m_edge  = 1'b0;
        m_state = 0;
        m_due   = 0;
        m_ce    = 1'b0;
        m_cnt   = '0;
        prev_ce = 1'b0;
    endtask

    task automatic tick();
        bit          c_cont, c_step, c_bpen, s_step, s_cont, pulse;
        logic [31:0] c_bp, c_pc;
        c_cont = bus.cont;
        c_step = bus.step;
        c_bpen = bus.bp_en;
        c_bp   = bus.bp_addr;
        c_pc   = bus.pc;
        @(posedge clk);
        n++;
        s_cont = q_cont.pop_front();
        q_cont.push_back(c_cont);
        s_step = q_step.pop_front();
        q_step.push_back(c_step);
        m_cnt = m_cnt + 32'(m_ce);
        pulse = 1'b0;
        case (m_state)
            0: begin
                pulse = m_edge;
                if (s_cont) begin
                    m_state = 1;
                    m_due   = n + RD;
                end
            end
            1: begin
                if (!s_cont) begin
                    m_state = 0;
                end else if (n == m_due) begin
                    m_due = m_due + RD;
                    if (c_bpen && c_pc == c_bp) m_state = 2;
                    else pulse = 1'b1;
                end
            end
            default: begin
                pulse = m_edge;
                if (!s_cont) m_state = 0;
            end
        endcase
        m_ce = pulse;
        if (s_step != m_db) begin
            m_dis++;
            if (m_dis == DB) begin
                m_db   = s_step;
                m_dis  = 0;
                m_edge = s_step;
            end else begin
                m_edge = 1'b0;
            end
        end else begin
            m_dis  = 0;
            m_edge = 1'b0;
        end
        #1;
        chk("cpu_ce", 32'(bus.cpu_ce), 32'(m_ce));
        chk("run_state", 32'(bus.run_state), 32'(m_state));
        chk("halted", 32'(bus.halted), 32'(m_state == 2));
        chk("ce_count", bus.ce_count, m_cnt);
        chk("ce_adjacent", 32'(prev_ce && bus.cpu_ce), 32'd0);
        if (bus.cpu_ce) begin
            pulses++;
            last_pulse_n = n;
        end
        if (cpu_auto && prev_ce) bus.pc = bus.pc + 32'd4;
        prev_ce = bus.cpu_ce;
        @(negedge clk);
    endtask

    initial begin
        int t0;
        int p0;
        bit bseq[10];
        rst          = 1'b1;
        bus.cont     = 1'b0;
        bus.step     = 1'b0;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        bus.pc       = '0;
        cpu_auto     = 1'b0;
        n            = 0;
        pulses       = 0;
        last_pulse_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_state", 32'(bus.run_state), 32'(ST_STEP));
        chk("rst_count", bus.ce_count, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // clean step press: one pulse, 7 cycles after the raise
        t0 = n;
        p0 = pulses;
        bus.step = 1'b1;
        repeat (10) tick();
        bus.step = 1'b0;
        repeat (12) tick();
        chk("step_pulses", 32'(pulses - p0), 32'd1);
        chk("step_latency", 32'(last_pulse_n - t0), 32'd7);
        chk("step_count", bus.ce_count, 32'd1);
        chk("step_state", 32'(bus.run_state), 32'd0);

        // bouncing press then a too-short press
        bseq = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            bus.step = bseq[i];
            tick();
        end
        bus.step = 1'b0;
        repeat (12) tick();
        chk("bounce_pulses", 32'(pulses - p0), 32'd1);
        p0 = pulses;
        bus.step = 1'b1;
        repeat (3) tick();
        bus.step = 1'b0;
        repeat (10) tick();
        chk("short_pulses", 32'(pulses - p0), 32'd0);
        chk("short_count", bus.ce_count, 32'd2);

        // continuous run
        bus.cont = 1'b1;
        for (int i = 0; i < 10 && bus.run_state != 2'd1; i++) tick();
        chk("run_entry", 32'(bus.run_state), 32'd1);
        p0 = pulses;
        repeat (40) tick();
        chk("run_pulses", 32'(pulses - p0), 32'd5);
        tick();
        chk("run_count", bus.ce_count, 32'd7);
        bus.cont = 1'b0;
        repeat (4) tick();
        chk("run_exit", 32'(bus.run_state), 32'd0);

        // breakpoint halt at pc 0xC
        bus.pc      = 32'h0;
        bus.bp_addr = 32'hC;
        bus.bp_en   = 1'b1;
        cpu_auto    = 1'b1;
        bus.cont    = 1'b1;
        p0 = pulses;
        for (int i = 0; i < 60 && !bus.halted; i++) tick();
        chk("bp_halted", 32'(bus.halted), 32'd1);
        chk("bp_state", 32'(bus.run_state), 32'd2);
        chk("bp_pulses", 32'(pulses - p0), 32'd3);

        // step over the breakpoint, drop cont, resume
        p0 = pulses;
        bus.step = 1'b1;
        repeat (8) tick();
        bus.step = 1'b0;
        repeat (10) tick();
        chk("halt_step_pulses", 32'(pulses - p0), 32'd1);
        chk("halt_step_state", 32'(bus.run_state), 32'd2);
        bus.cont = 1'b0;
        repeat (4) tick();
        chk("halt_drop", 32'(bus.run_state), 32'd0);
        bus.cont = 1'b1;
        for (int i = 0; i < 10 && bus.run_state != 2'd1; i++) tick();
        chk("resume_state", 32'(bus.run_state), 32'd1);
        p0 = pulses;
        repeat (16) tick();
        chk("resume_pulses", 32'(pulses - p0), 32'd2);

        // async reset on the divider's terminal cycle
        for (int i = 0; i < 20 && !(m_state == 1 && n + 1 == m_due); i++)
            tick();
        chk("tc_reached", 32'(n + 1 == m_due), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cpu_ce", 32'(bus.cpu_ce), 32'd0);
        chk("arst_count", bus.ce_count, 32'd0);
        chk("arst_state", 32'(bus.run_state), 32'd0);
        model_reset();
        bus.cont  = 1'b0;
        bus.bp_en = 1'b0;
        bus.pc    = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // random run
        bus.bp_addr = 32'(4 * $urandom_range(1, 6));
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 5) == 0) bus.step = ~bus.step;
            if ($urandom_range(0, 39) == 0) bus.cont = ~bus.cont;
            if ($urandom_range(0, 49) == 0) bus.bp_en = ~bus.bp_en;
            tick();
        end

        // async reset in the middle of a pulse
        bus.step  = 1'b0;
        bus.bp_en = 1'b0;
        bus.cont  = 1'b0;
        repeat (6) tick();
        bus.cont = 1'b1;
        for (int i = 0; i < 40 && !bus.cpu_ce; i++) tick();
        chk("pulse_seen", 32'(bus.cpu_ce), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst2_cpu_ce", 32'(bus.cpu_ce), 32'd0);
        chk("arst2_count", bus.ce_count, 32'd0);
        chk("arst2_halted", 32'(bus.halted), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
